ingredient_timer: RTL and testbench

- Dispense-duration timer that closes the loop with the coffee-maker control FSM.
- Consumes the FSM's `start_timer` pulse and `ing_type` code, loads the per-ingredient dispense time, counts it down in seconds derived from `clk`, and returns a one-cycle `t_expired` pulse that advances the FSM to the next ingredient.
- Also exposes remaining seconds for a display stage.

---
 rtl/ingredient_timer.sv | 89 ++++++++
 tb/tb_ingredient_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ingredient_timer.sv
// rtl/ingredient_timer.sv - per-ingredient dispense countdown with one-cycle expiry pulse
module ingredient_timer #(
  parameter int         CLK_DIV = 50000000,
  parameter logic [7:0] T_ING0  = 8'd5,
  parameter logic [7:0] T_ING1  = 8'd3,
  parameter logic [7:0] T_ING2  = 8'd4,
  parameter logic [7:0] T_ING3  = 8'd2,
  parameter logic [7:0] T_ING4  = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [2:0] ing_type,
  input  logic       abort,
  output logic       t_expired,
  output logic       busy,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] prescaler;
  logic [7:0]    dur;
  logic          tick;

  always_comb begin
    case (ing_type)
      3'd0:    dur = T_ING0;
      3'd1:    dur = T_ING1;
      3'd2:    dur = T_ING2;
      3'd3:    dur = T_ING3;
      3'd4:    dur = T_ING4;
      default: dur = 8'd0;
    endcase
  end

  assign tick = (state == RUN) && (prescaler == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // abort beats start; start is honoured in every state and restarts a running count
  always_comb begin
    state_nxt = state;
    if (abort)
      state_nxt = IDLE;
    else if (start_timer)
      state_nxt = (dur != 8'd0) ? RUN : DONE;
    else begin
      case (state)
        RUN:     if (tick && remaining == 8'd1) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      remaining <= 8'd0;
    end else if (abort) begin
      prescaler <= '0;
      remaining <= 8'd0;
    end else if (start_timer) begin
      prescaler <= '0;
      remaining <= dur;
    end else if (state == RUN) begin
      if (tick) begin
        prescaler <= '0;
        remaining <= remaining - 8'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_comb begin
    t_expired = (state == DONE);
    busy      = (state == RUN);
  end

endmodule

// File: tb/tb_ingredient_timer.sv
// tb/tb_ingredient_timer.sv - table, directed and random checks of ingredient_timer against a time-based model
module tb_ingredient_timer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [2:0] ing_type = 3'd0;
  logic       abort = 1'b0;
  logic       t_expired;
  logic       busy;
  logic [7:0] remaining;

  ingredient_timer #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(start_timer),
    .ing_type   (ing_type),
    .abort      (abort),
    .t_expired  (t_expired),
    .busy       (busy),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;
  int last_pulse_cyc = -1;

  // Model: a count is an absolute start edge plus a duration; outputs follow from elapsed edges
  int cyc = 0;
  bit m_active = 0;
  int m_start = 0;
  int m_dur = 0;
  logic       e_te, e_busy;
  logic [7:0] e_rem;

  function automatic int dur_of(input logic [2:0] code);
    int t [5] = '{5, 3, 4, 2, 6};
    return (code < 3'd5) ? t[code] : 0;
  endfunction

  task automatic model_edge(input logic s, input logic [2:0] i, input logic a);
    cyc++;
    if (a) m_active = 0;
    else if (s) begin
      m_active = 1;
      m_start  = cyc;
      m_dur    = dur_of(i);
    end
    e_te = 0; e_busy = 0; e_rem = 0;
    if (m_active) begin
      if (cyc - m_start == m_dur * DIV) begin
        e_te = 1;
        m_active = 0;
      end else begin
        e_busy = 1;
        e_rem  = 8'(m_dur - (cyc - m_start) / DIV);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] i, input logic a, input bit use_model);
    start_timer = s; ing_type = i; abort = a;
    @(posedge clk);
    model_edge(s, i, a);
    @(negedge clk);
    start_timer = 0; abort = 0;
    if (t_expired === 1'b1) begin pulses++; last_pulse_cyc = cyc; end
    if (use_model) begin
      if ({t_expired, busy, remaining} !== {e_te, e_busy, e_rem}) begin
        chk("model_t_expired", int'(t_expired), int'(e_te));
        chk("model_busy", int'(busy), int'(e_busy));
        chk("model_remaining", int'(remaining), int'(e_rem));
      end else vectors++;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_active = 0;
  endtask

  typedef struct {
    logic       s;
    logic [2:0] ing;
    logic       a;
    logic       te;
    logic       bz;
    logic [7:0] rem;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic [2:0] i, input logic a,
                              input logic te, input logic bz, input logic [7:0] r);
    vec_t v;
    v.s = s; v.ing = i; v.a = a; v.te = te; v.bz = bz; v.rem = r;
    return v;
  endfunction

  initial begin
    int p0, t0;

    // invalid code expires at once; then back-to-back D=2 counts restarted in the DONE cycle
    tbl.push_back(mk(1, 3'd6, 0, 1, 0, 8'd0));
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 8'd0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1, 3'd3, 0, 0, 1, 8'd2));
      for (int e = 1; e < 8; e++) tbl.push_back(mk(0, 3'd0, 0, 0, 1, (e < 4) ? 8'd2 : 8'd1));
      tbl.push_back(mk(0, 3'd0, 0, 1, 0, 8'd0));
    end
    tbl.push_back(mk(0, 3'd0, 0, 0, 0, 8'd0));

    #2;
    chk("reset_t_expired", int'(t_expired), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_remaining", int'(remaining), 0);
    do_reset();

    foreach (tbl[n]) begin
      step(tbl[n].s, tbl[n].ing, tbl[n].a, 0);
      chk($sformatf("tbl%0d_t_expired", n), int'(t_expired), int'(tbl[n].te));
      chk($sformatf("tbl%0d_busy", n), int'(busy), int'(tbl[n].bz));
      chk($sformatf("tbl%0d_remaining", n), int'(remaining), int'(tbl[n].rem));
    end

    // ing 0: 5 seconds, single pulse 20 edges after start
    pulses = 0;
    step(1, 3'd0, 0, 1);
    t0 = cyc;
    for (int n = 0; n < 24; n++) step(0, 3'd0, 0, 1);
    chk("t1_pulse_count", pulses, 1);
    chk("t1_pulse_delay", last_pulse_cyc - t0, 20);

    // restart during RUN: ing 4 interrupted at remaining 3 by ing 3
    pulses = 0;
    step(1, 3'd4, 0, 1);
    for (int n = 0; n < 12; n++) step(0, 3'd0, 0, 1);
    chk("t3_rem_before_restart", int'(remaining), 3);
    step(1, 3'd3, 0, 1);
    t0 = cyc;
    chk("t3_rem_reload", int'(remaining), 2);
    for (int n = 0; n < 12; n++) step(0, 3'd0, 0, 1);
    chk("t3_pulse_count", pulses, 1);
    chk("t3_pulse_delay", last_pulse_cyc - t0, 8);

    // abort wins over a simultaneous start
    step(1, 3'd1, 0, 1);
    for (int n = 0; n < 4; n++) step(0, 3'd0, 0, 1);
    chk("t4_rem_before_abort", int'(remaining), 2);
    pulses = 0;
    step(1, 3'd1, 1, 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_remaining", int'(remaining), 0);
    for (int n = 0; n < 30; n++) step(0, 3'd0, 0, 1);
    chk("t4_no_pulse", pulses, 0);

    // asynchronous reset mid-count
    step(1, 3'd2, 0, 1);
    for (int n = 0; n < 8; n++) step(0, 3'd0, 0, 1);
    chk("t5_rem_before_reset", int'(remaining), 2);
    #1 reset = 1;
    #1;
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_remaining", int'(remaining), 0);
    chk("t5_async_t_expired", int'(t_expired), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_active = 0;
    pulses = 0;
    for (int n = 0; n < 30; n++) step(0, 3'd0, 0, 1);
    chk("t5_no_pulse", pulses, 0);

    // random traffic
    p0 = 0;
    for (int n = 0; n < 1500; n++) begin
      logic s, a;
      logic [2:0] i;
      s = ($urandom_range(0, 14) == 0);
      a = ($urandom_range(0, 39) == 0);
      i = 3'($urandom_range(0, 7));
      step(s, i, a, 1);
      if (t_expired) p0++;
    end
    chk("rand_some_pulses", int'(p0 > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
